// File: rtl/regfile_pkg.sv
// Shared constants and the queued-write entry type for the register-file write arbiter.
package regfile_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] data;
    logic              live;
  } wq_entry_t;
endpackage

// File: rtl/regfile_wq_fifo.sv
// In-order secondary-write queue with per-entry live bits, squash-by-register
// and a registered per-register pending map built from live entries.
module regfile_wq_fifo #(
  parameter int QDEPTH = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   i_push,
  input  regfile_pkg::wq_entry_t                 i_push_entry,
  input  logic                                   i_pop,
  input  logic                                   i_squash_en,
  input  logic [regfile_pkg::ADDR_W-1:0]         i_squash_reg,
  output regfile_pkg::wq_entry_t                 o_head,
  output logic [$clog2(QDEPTH):0]                o_count,
  output logic [(1<<regfile_pkg::ADDR_W)-1:0]    o_pend_busy
);
  import regfile_pkg::*;

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int NREGS = 1 << ADDR_W;

  wq_entry_t          r_mem [QDEPTH];
  logic [QDEPTH-1:0]  r_live;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W:0]     r_count;
  logic [NREGS-1:0]   r_pend;

  logic [QDEPTH-1:0]  w_live_nxt;
  logic [ADDR_W-1:0]  w_reg_nxt [QDEPTH];
  logic [NREGS-1:0]   w_pend_nxt;

  // Squash only looks at resident entries; the tail write below lands after it,
  // so an entry pushed on the same edge as a pipeline write survives.
  always_comb begin
    w_live_nxt = r_live;
    for (int i = 0; i < QDEPTH; i++) begin
      w_reg_nxt[i] = r_mem[i].reg_addr;
      if (i_squash_en && r_live[i] && (r_mem[i].reg_addr == i_squash_reg))
        w_live_nxt[i] = 1'b0;
    end
    if (i_pop)
      w_live_nxt[r_rd_ptr] = 1'b0;
    if (i_push) begin
      w_live_nxt[r_wr_ptr] = i_push_entry.live;
      w_reg_nxt[r_wr_ptr]  = i_push_entry.reg_addr;
    end
  end

  always_comb begin
    w_pend_nxt = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (w_live_nxt[i])
        w_pend_nxt[w_reg_nxt[i]] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_live   <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_pend   <= '0;
    end else begin
      r_live <= w_live_nxt;
      r_pend <= w_pend_nxt;
      if (i_push)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push)
      r_mem[r_wr_ptr] <= i_push_entry;
  end

  always_comb begin
    o_head          = r_mem[r_rd_ptr];
    o_head.live     = r_live[r_rd_ptr];
  end

  assign o_count     = r_count;
  assign o_pend_busy = r_pend;
endmodule

// File: rtl/regfile_write_arbiter.sv
// Merges pipeline writeback (always wins) and a queued secondary write source
// onto the register file's single registered write port.
module regfile_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int QDEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pipe_we,
  input  logic [ADDR_W-1:0]        pipe_reg,
  input  logic [DATA_W-1:0]        pipe_data,
  input  logic                     aux_valid,
  output logic                     aux_ready,
  input  logic [ADDR_W-1:0]        aux_reg,
  input  logic [DATA_W-1:0]        aux_data,
  output logic                     RegWrite,
  output logic [ADDR_W-1:0]        Write_Reg,
  output logic [DATA_W-1:0]        Write_Bus,
  output logic [31:0]              pend_busy,
  output logic [$clog2(QDEPTH):0]  q_count
);
  import regfile_pkg::*;

  localparam int CNT_W = $clog2(QDEPTH) + 1;
  localparam logic [CNT_W-1:0] QFULL = CNT_W'(QDEPTH);

  logic       w_pipe_issue;
  logic       w_push;
  logic       w_pop;
  wq_entry_t  w_push_entry;
  wq_entry_t  w_head;

  logic              r_we;
  logic [ADDR_W-1:0] r_wreg;
  logic [DATA_W-1:0] r_wbus;

  // A pipeline write to r0 is a no-op and leaves the cycle free for a pop.
  assign w_pipe_issue = pipe_we && (pipe_reg != REG_ZERO);
  assign aux_ready    = (q_count < QFULL) && !rst;
  assign w_push       = aux_valid && aux_ready;
  assign w_pop        = !w_pipe_issue && (q_count != '0);

  always_comb begin
    w_push_entry.reg_addr = aux_reg;
    w_push_entry.data     = aux_data;
    w_push_entry.live     = (aux_reg != REG_ZERO);
  end

  regfile_wq_fifo #(
    .QDEPTH (QDEPTH)
  ) u_wq (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .i_squash_en  (w_pipe_issue),
    .i_squash_reg (pipe_reg),
    .o_head       (w_head),
    .o_count      (q_count),
    .o_pend_busy  (pend_busy)
  );

  // Output register: squashed heads burn a cycle with the write enable low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we   <= 1'b0;
      r_wreg <= '0;
      r_wbus <= '0;
    end else if (w_pipe_issue) begin
      r_we   <= 1'b1;
      r_wreg <= pipe_reg;
      r_wbus <= pipe_data;
    end else if (w_pop) begin
      r_we <= w_head.live;
      if (w_head.live) begin
        r_wreg <= w_head.reg_addr;
        r_wbus <= w_head.data;
      end
    end else begin
      r_we <= 1'b0;
    end
  end

  assign RegWrite  = r_we;
  assign Write_Reg = r_wreg;
  assign Write_Bus = r_wbus;
endmodule
